tensor_core_sequencer: RTL and testbench
========================================

Name: tensor_core_sequencer

Overview:
Sequences tensor core MMA operations and arbitrates access to the tensor core register file's non-bulk write port. Non-bulk writes (load-immediate, CPU-to-tensor-core moves) arriving while an MMA is in flight are held in a small FIFO and are never applied mid-calculation. Bulk writeback of the MMA result is only permitted while an operation is outstanding. Sits between the CPU instruction decode and the tensor_core_register_file / small_tensor_core pair.

Parameters:
DATA_WIDTH, 8, width of one tensor core register element
FIFO_DEPTH, 4, non-bulk write buffer entries (power of two, >=2)
TIMEOUT_CYCLES, 64, max cycles waiting for tc_done_in before aborting

Ports:
clock_in  input  1  clock, all state on rising edge
reset_in  input  1  synchronous, active-high reset
op_valid_in  input  1  request to run one MMA
op_ready_out  output  1  MMA request accepted when valid&ready
wr_valid_in  input  1  non-bulk write request
wr_ready_out  output  1  write accepted when valid&ready
wr_address_in  input  5  tensor core register address
wr_data_in  input  DATA_WIDTH  write data
tc_start_out  output  1  one-cycle start pulse to tensor core
tc_done_in  input  1  tensor core done-with-calculation
rf_wr_enable_out  output  1  non-bulk write enable to register file
rf_wr_address_out  output  5  non-bulk write address
rf_wr_data_out  output  DATA_WIDTH  non-bulk write data
rf_bulk_enable_out  output  1  gated bulk write enable to register file
busy_out  output  1  high in START or COMPUTE
timeout_error_out  output  1  sticky abort flag
ops_completed_out  output  16  count of completed MMAs

Behaviour:
- Reset (reset_in high at a clock edge): state IDLE, FIFO empty, ops_completed_out=0, timeout_error_out=0. All other outputs are 0 while reset_in is high, including both readies. Reset mid-COMPUTE discards the operation and all buffered writes.
- FIFO: push on wr_valid_in&wr_ready_out in any state. wr_ready_out = !full, computed from registered count. A push and pop in the same cycle leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Drain: only in IDLE, one entry per cycle, head entry driven on rf_wr_*_out with rf_wr_enable_out=1. Without bypass, latency from acceptance to rf write is 1 cycle when IDLE.
- op_ready_out = (state==IDLE) & fifo_empty & !wr_valid_in. A write presented in the same cycle as an op is ordered first, so the op waits until the write has drained.
- FSM:
  - IDLE -> START on op accept.
  - START: tc_start_out=1 for exactly this cycle; timeout counter cleared; -> COMPUTE.
  - COMPUTE: counter increments each cycle. On tc_done_in: rf_bulk_enable_out=1 that same cycle (combinational), ops_completed_out increments (wraps 0xFFFF->0), -> IDLE. If the counter reaches TIMEOUT_CYCLES-1 without done: timeout_error_out set, -> IDLE, no bulk write.
  - If done and timeout occur in the same cycle, done wins.
- tc_done_in outside COMPUTE is ignored: rf_bulk_enable_out stays 0 and nothing is counted.
- timeout_error_out clears only on reset.
- busy_out = state in {START, COMPUTE}.
- Throughput: back-to-back ops with no writes pending start every (compute latency + 2) cycles.

Optional Feature:
TC_SEQ_WRITE_BYPASS_EN
- Defined: in IDLE with the FIFO empty, an accepted write is driven onto rf_wr_*_out combinationally in the same cycle (0-cycle latency) and is not pushed into the FIFO.
- Undefined: all writes go through the FIFO (1-cycle latency in IDLE).
- op_ready_out ordering is identical in both builds.

Test Plan:
- Reset, then IDLE write addr=3 data=0x5A -> rf_wr_enable_out high 1 cycle later with addr 3, data 0x5A (same cycle if bypass enabled).
- Op accepted; tc_done_in asserted 5 cycles after tc_start_out -> single-cycle start pulse, busy_out high for 6 cycles, rf_bulk_enable_out high only on the done cycle, ops_completed_out=1.
- During COMPUTE push writes 0x11,0x22,0x33,0x44 (depth 4), then a 5th -> 5th stalls with wr_ready_out=0, no rf writes until done, then the 4 entries drain in order on 4 consecutive cycles and the 5th is then accepted.
- tc_done_in pulsed while IDLE -> rf_bulk_enable_out stays 0, counter unchanged.
- No done for 64 cycles after start -> timeout_error_out=1 on cycle 64, return to IDLE, next op accepted, error stays set; reset clears it.
- op_valid_in and wr_valid_in together in IDLE with empty FIFO -> write accepted, op_ready_out=0 that cycle, op accepted the cycle after the write drains.

Source files
------------

// File: rtl/tensor_core_sequencer.sv
// Tensor core MMA sequencer and non-bulk register file write arbiter.
// Optional build macro TC_SEQ_WRITE_BYPASS_EN: zero-latency writes when idle and empty.
module tensor_core_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  op_valid_in,
    output logic                  op_ready_out,
    input  logic                  wr_valid_in,
    output logic                  wr_ready_out,
    input  logic [4:0]            wr_address_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    output logic                  tc_start_out,
    input  logic                  tc_done_in,
    output logic                  rf_wr_enable_out,
    output logic [4:0]            rf_wr_address_out,
    output logic [DATA_WIDTH-1:0] rf_wr_data_out,
    output logic                  rf_bulk_enable_out,
    output logic                  busy_out,
    output logic                  timeout_error_out,
    output logic [15:0]           ops_completed_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, COMPUTE} state_t;

    state_t                state;
    logic [4:0]            fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW:0]           count;
    logic [TW-1:0]         timer;
    logic [15:0]           ops_count;
    logic                  timeout_flag;

    logic idle;
    logic empty;
    logic full;
    logic wr_fire;
    logic bypass;
    logic push;
    logic pop;
    logic op_fire;

    assign idle    = (state == IDLE);
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign wr_fire = wr_valid_in & wr_ready_out;
    assign op_fire = op_valid_in & op_ready_out;

`ifdef TC_SEQ_WRITE_BYPASS_EN
    assign bypass = wr_fire & idle & empty;
`else
    assign bypass = 1'b0;
`endif

    assign push = wr_fire & ~bypass;
    assign pop  = idle & ~empty & ~reset_in;

    assign wr_ready_out = ~reset_in & ~full;
    // A same-cycle write is ordered ahead of the op, so the op waits for it.
    assign op_ready_out = ~reset_in & idle & empty & ~wr_valid_in;

    assign rf_wr_enable_out  = pop | bypass;
    assign rf_wr_address_out = pop ? fifo_addr[head]
                             : (bypass ? wr_address_in : '0);
    assign rf_wr_data_out    = pop ? fifo_data[head]
                             : (bypass ? wr_data_in : '0);

    assign rf_bulk_enable_out = ~reset_in & (state == COMPUTE) & tc_done_in;
    assign tc_start_out       = ~reset_in & (state == START);
    assign busy_out           = ~reset_in & ~idle;
    assign timeout_error_out  = ~reset_in & timeout_flag;
    assign ops_completed_out  = reset_in ? '0 : ops_count;

    always_ff @(posedge clock_in) begin
        if (push) begin
            fifo_addr[tail] <= wr_address_in;
            fifo_data[tail] <= wr_data_in;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state        <= IDLE;
            timer        <= '0;
            ops_count    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_fire) state <= START;
                end
                START: begin
                    timer <= '0;
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    // Done takes priority over a coincident timeout.
                    if (tc_done_in) begin
                        ops_count <= ops_count + 16'd1;
                        state     <= IDLE;
                    end else if (timer == TIMER_MAX) begin
                        timeout_flag <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Self-checking bench for tensor_core_sequencer: vector table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_tensor_core_sequencer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 64;

    logic          clock_in = 1'b0;
    logic          reset_in;
    logic          op_valid_in;
    logic          op_ready_out;
    logic          wr_valid_in;
    logic          wr_ready_out;
    logic [4:0]    wr_address_in;
    logic [DW-1:0] wr_data_in;
    logic          tc_start_out;
    logic          tc_done_in;
    logic          rf_wr_enable_out;
    logic [4:0]    rf_wr_address_out;
    logic [DW-1:0] rf_wr_data_out;
    logic          rf_bulk_enable_out;
    logic          busy_out;
    logic          timeout_error_out;
    logic [15:0]   ops_completed_out;

    tensor_core_sequencer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock_in(clock_in),
        .reset_in(reset_in),
        .op_valid_in(op_valid_in),
        .op_ready_out(op_ready_out),
        .wr_valid_in(wr_valid_in),
        .wr_ready_out(wr_ready_out),
        .wr_address_in(wr_address_in),
        .wr_data_in(wr_data_in),
        .tc_start_out(tc_start_out),
        .tc_done_in(tc_done_in),
        .rf_wr_enable_out(rf_wr_enable_out),
        .rf_wr_address_out(rf_wr_address_out),
        .rf_wr_data_out(rf_wr_data_out),
        .rf_bulk_enable_out(rf_bulk_enable_out),
        .busy_out(busy_out),
        .timeout_error_out(timeout_error_out),
        .ops_completed_out(ops_completed_out)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a queue, the op as a phase
    // plus the cycle number at which its start pulse happened.
    typedef struct packed {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t q[$];
    int  m_phase;
    int  m_t0;
    int  m_ops;
    bit  m_err;
    int  cyc;

    bit            o_op, o_wr, o_en, o_start, o_busy, o_bulk, o_err;
    logic [4:0]    o_a;
    logic [DW-1:0] o_d;
    int            o_ops;

    task automatic model_clear();
        q.delete();
        m_phase = 0;
        m_t0    = 0;
        m_ops   = 0;
        m_err   = 0;
    endtask

    task automatic tick(input bit ov, input bit wv, input logic [4:0] a,
                        input logic [DW-1:0] d, input bit dn);
        bit            idle, byp, e_wr, e_op, e_en;
        logic [4:0]    e_a;
        logic [DW-1:0] e_d;
        op_valid_in   = ov;
        wr_valid_in   = wv;
        wr_address_in = a;
        wr_data_in    = d;
        tc_done_in    = dn;
        @(negedge clock_in);
        idle = (m_phase == 0);
        byp  = 1'b0;
`ifdef TC_SEQ_WRITE_BYPASS_EN
        byp  = idle && q.size() == 0 && wv;
`endif
        e_wr = q.size() < DEPTH;
        e_op = idle && q.size() == 0 && !wv;
        e_en = (idle && q.size() > 0) || byp;
        e_a  = (idle && q.size() > 0) ? q[0].a : a;
        e_d  = (idle && q.size() > 0) ? q[0].d : d;
        o_op = op_ready_out;    o_wr = wr_ready_out;
        o_en = rf_wr_enable_out; o_a = rf_wr_address_out;
        o_d  = rf_wr_data_out;  o_start = tc_start_out;
        o_busy = busy_out;      o_bulk = rf_bulk_enable_out;
        o_err = timeout_error_out; o_ops = int'(ops_completed_out);
        chk("op_ready", op_ready_out, e_op);
        chk("wr_ready", wr_ready_out, e_wr);
        chk("rf_wr_enable", rf_wr_enable_out, e_en);
        if (e_en) begin
            chk("rf_wr_address", rf_wr_address_out, e_a);
            chk("rf_wr_data", rf_wr_data_out, e_d);
        end
        chk("tc_start", tc_start_out, m_phase == 1);
        chk("busy", busy_out, m_phase != 0);
        chk("bulk_enable", rf_bulk_enable_out, m_phase == 2 && dn);
        chk("timeout_error", timeout_error_out, m_err);
        chk("ops_completed", ops_completed_out, m_ops);
        if (idle && q.size() > 0) q.delete(0);
        if (wv && e_wr && !byp) q.push_back({a, d});
        if (m_phase == 0) begin
            if (ov && e_op) begin
                m_phase = 1;
                m_t0    = cyc + 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (dn) begin
            m_ops   = (m_ops + 1) % 65536;
            m_phase = 0;
        end else if (cyc == m_t0 + TO) begin
            m_err   = 1;
            m_phase = 0;
        end
        cyc++;
        @(posedge clock_in);
        #1;
    endtask

    task automatic do_reset();
        reset_in      = 1'b1;
        op_valid_in   = 1'b1;
        wr_valid_in   = 1'b1;
        wr_address_in = 5'h1F;
        wr_data_in    = 8'hFF;
        tc_done_in    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock_in);
            chk("rst_op_ready", op_ready_out, 0);
            chk("rst_wr_ready", wr_ready_out, 0);
            chk("rst_rf_en", rf_wr_enable_out, 0);
            chk("rst_rf_addr", rf_wr_address_out, 0);
            chk("rst_rf_data", rf_wr_data_out, 0);
            chk("rst_start", tc_start_out, 0);
            chk("rst_bulk", rf_bulk_enable_out, 0);
            chk("rst_busy", busy_out, 0);
            chk("rst_err", timeout_error_out, 0);
            chk("rst_ops", ops_completed_out, 0);
            @(posedge clock_in);
            #1;
            cyc++;
        end
        reset_in    = 1'b0;
        op_valid_in = 1'b0;
        wr_valid_in = 1'b0;
        tc_done_in  = 1'b0;
        model_clear();
    endtask

    typedef struct {
        bit            ov, wv, dn;
        logic [4:0]    a;
        logic [DW-1:0] d;
        bit            e_op, e_wr, e_en, e_busy, e_bulk;
        logic [4:0]    e_a;
        logic [DW-1:0] e_d;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int sc, bc, kc, hold, pct;
        logic [DW-1:0] got[$];
        int gcyc[$];

        cyc = 0;
        model_clear();
        do_reset();

        // IDLE write latency, done ignored in IDLE.
`ifdef TC_SEQ_WRITE_BYPASS_EN
        tbl[0] = '{1'b0, 1'b1, 1'b0, 5'd3, 8'h5A, 0, 1, 1, 0, 0, 5'd3, 8'h5A};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1, 1, 0, 0, 0, 5'd0, 8'h00};
`else
        tbl[0] = '{1'b0, 1'b1, 1'b0, 5'd3, 8'h5A, 0, 1, 0, 0, 0, 5'd0, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 0, 1, 1, 0, 0, 5'd3, 8'h5A};
`endif
        tbl[2] = '{1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 1, 1, 0, 0, 0, 5'd0, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1, 1, 0, 0, 0, 5'd0, 8'h00};
        for (int i = 0; i < 4; i++) begin
            tick(tbl[i].ov, tbl[i].wv, tbl[i].a, tbl[i].d, tbl[i].dn);
            chk("tbl_op_ready", o_op, tbl[i].e_op);
            chk("tbl_wr_ready", o_wr, tbl[i].e_wr);
            chk("tbl_rf_en", o_en, tbl[i].e_en);
            if (tbl[i].e_en) begin
                chk("tbl_rf_addr", o_a, tbl[i].e_a);
                chk("tbl_rf_data", o_d, tbl[i].e_d);
            end
            chk("tbl_busy", o_busy, tbl[i].e_busy);
            chk("tbl_bulk", o_bulk, tbl[i].e_bulk);
        end
        chk("idle_done_ops", o_ops, 0);

        // Single MMA, done 5 cycles after the start pulse.
        do_reset();
        tick(1, 0, 0, 0, 0);
        chk("mma_accept", o_op, 1);
        sc = 0; bc = 0; kc = 0;
        for (int k = 1; k <= 6; k++) begin
            tick(0, 0, 0, 0, k == 6);
            sc += int'(o_start); bc += int'(o_busy); kc += int'(o_bulk);
            if (k == 1) chk("mma_start_first", o_start, 1);
            if (k == 6) chk("mma_bulk_on_done", o_bulk, 1);
        end
        tick(0, 0, 0, 0, 0);
        chk("mma_start_count", sc, 1);
        chk("mma_busy_cycles", bc, 6);
        chk("mma_bulk_count", kc, 1);
        chk("mma_busy_after", o_busy, 0);
        chk("mma_ops", o_ops, 1);

        // Writes buffered during COMPUTE, 5th stalls, ordered drain.
        do_reset();
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 5'(i), 8'(8'h11 * (i + 1)), 0);
            chk("fifo_push_ready", o_wr, 1);
            chk("fifo_no_rf_write", o_en, 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 5'd4, 8'h55, 0);
            chk("fifo_full_stall", o_wr, 0);
            chk("fifo_full_no_rf", o_en, 0);
        end
        tick(0, 1, 5'd4, 8'h55, 1);
        chk("fifo_done_bulk", o_bulk, 1);
        hold = 1;
        for (int j = 0; j < 8; j++) begin
            tick(0, hold != 0, 5'd4, 8'h55, 0);
            if (hold != 0 && o_wr) hold = 0;
            if (o_en) begin
                got.push_back(o_d);
                gcyc.push_back(j);
            end
        end
        chk("fifo_drain_count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++)
            chk("fifo_drain_order", got[k], 8'(8'h11 * (k + 1)));
        if (gcyc.size() == 5) chk("fifo_drain_consecutive", gcyc[4] - gcyc[0], 4);

        // Timeout after 64 compute cycles, sticky until reset.
        do_reset();
        tick(1, 0, 0, 0, 0);
        bc = 0;
        for (int n = 0; n < 80; n++) begin
            tick(0, 0, 0, 0, 0);
            if (!o_busy) break;
            bc++;
        end
        chk("timeout_busy_cycles", bc, 65);
        chk("timeout_flag_set", o_err, 1);
        tick(1, 0, 0, 0, 0);
        chk("timeout_next_accept", o_op, 1);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        chk("timeout_sticky", o_err, 1);
        chk("timeout_ops", o_ops, 1);
        do_reset();
        tick(0, 0, 0, 0, 0);
        chk("timeout_cleared", o_err, 0);

        // Done on the last possible compute cycle beats the timeout.
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        for (int n = 0; n < TO - 1; n++) tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        chk("edge_done_bulk", o_bulk, 1);
        tick(0, 0, 0, 0, 0);
        chk("edge_done_no_err", o_err, 0);
        chk("edge_done_ops", o_ops, 1);

        // Op and write together: write goes first.
        do_reset();
        tick(1, 1, 5'd7, 8'hC3, 0);
        chk("order_op_blocked", o_op, 0);
        chk("order_wr_accept", o_wr, 1);
`ifdef TC_SEQ_WRITE_BYPASS_EN
        chk("order_bypass_write", o_en, 1);
        tick(1, 0, 0, 0, 0);
        chk("order_op_accept", o_op, 1);
`else
        tick(1, 0, 0, 0, 0);
        chk("order_drain", o_en, 1);
        chk("order_drain_data", o_d, 8'hC3);
        chk("order_op_wait", o_op, 0);
        tick(1, 0, 0, 0, 0);
        chk("order_op_accept", o_op, 1);
`endif
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);

        // Reset mid-compute discards the op and buffered writes.
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 1, 5'd9, 8'h99, 0);
        do_reset();
        tick(0, 0, 0, 0, 0);
        chk("midrst_no_drain", o_en, 0);
        chk("midrst_idle", o_op, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            pct = (i < 1000) ? 25 : ((i < 2000) ? 3 : 0);
            if (i == 2500) do_reset();
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 5'($urandom), 8'($urandom),
                 $urandom_range(0, 99) < pct);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
